// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
package riscv_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam int TO_CNT_W = 8;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: legality, byte enables, store replication and
// load extension. Holds no state.
module lsu_align
   import riscv_mem_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_lane,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   input  logic        i_is_store,
   output logic        o_bad,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata_ext
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[7:0];
      unique case (i_lane)
         2'd0: w_byte = i_rdata[7:0];
         2'd1: w_byte = i_rdata[15:8];
         2'd2: w_byte = i_rdata[23:16];
         2'd3: w_byte = i_rdata[31:24];
      endcase
      w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   always_comb begin
      o_bad = 1'b0;
      case (i_funct3[1:0])
         2'b11:   o_bad = 1'b1;
         2'b01:   o_bad = i_lane[0];
         2'b10:   o_bad = |i_lane;
         default: o_bad = 1'b0;
      endcase
   end

   // Loads always fetch the whole word; only stores narrow the enables.
   always_comb begin
      o_be    = 4'b1111;
      o_wdata = i_wdata;
      if (i_is_store) begin
         case (i_funct3[1:0])
            2'b00: begin
               o_be    = 4'b0001 << i_lane;
               o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
               o_be    = 4'b0011 << i_lane;
               o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
               o_be    = 4'b1111;
               o_wdata = i_wdata;
            end
         endcase
      end
   end

   always_comb begin
      o_rdata_ext = i_rdata;
      case (i_funct3)
         F3_LB:   o_rdata_ext = {{24{w_byte[7]}}, w_byte};
         F3_LBU:  o_rdata_ext = {24'd0, w_byte};
         F3_LH:   o_rdata_ext = {{16{w_half[15]}}, w_half};
         F3_LHU:  o_rdata_ext = {16'd0, w_half};
         default: o_rdata_ext = i_rdata;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store sequencer: issues one req/ack transaction per access,
// stalls the pipeline while it is outstanding and reports faults.
//
// state | meaning
// IDLE  | no access outstanding; issue, fault or pass through
// WAIT  | request on the bus, waiting for dmem_ack or timeout
// RESP  | result presented to MEM/WB, pipeline advances this edge
module dmem_access_ctrl
   import riscv_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read_mem,
   input  logic        mem_write_mem,
   input  logic [31:0] alu_result_mem,
   input  logic [31:0] write_data_mem,
   input  logic [2:0]  funct3_mem,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall_mem,
   output logic        bubble_wb,
   output logic [31:0] read_data_mem,
   output logic        misaligned_fault,
   output logic        timeout_fault
);

   localparam logic [TO_CNT_W-1:0] LP_CNT_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [TO_CNT_W-1:0]  r_cnt;
   logic [31:0]          r_rdata_q;
   logic                 r_timeout;
   logic                 w_access;
   logic                 w_fmt_bad;
   logic                 w_issue;
   logic                 w_done;
   logic                 w_tmo;
   logic [3:0]           w_be;
   logic [31:0]          w_wdata_rep;
   logic [31:0]          w_rdata_ext;

   assign w_access = mem_read_mem | mem_write_mem;

   lsu_align u_lsu_align (
      .i_funct3    (funct3_mem),
      .i_lane      (alu_result_mem[1:0]),
      .i_wdata     (write_data_mem),
      .i_rdata     (r_rdata_q),
      .i_is_store  (mem_write_mem),
      .o_bad       (w_fmt_bad),
      .o_be        (w_be),
      .o_wdata     (w_wdata_rep),
      .o_rdata_ext (w_rdata_ext)
   );

   always_comb begin
      w_state_nxt      = r_state;
      w_issue          = 1'b0;
      w_done           = 1'b0;
      w_tmo            = 1'b0;
      stall_mem        = 1'b0;
      bubble_wb        = 1'b0;
      read_data_mem    = 32'd0;
      misaligned_fault = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_access && w_fmt_bad) begin
               misaligned_fault = 1'b1;
            end else if (w_access) begin
               w_issue     = 1'b1;
               stall_mem   = 1'b1;
               bubble_wb   = 1'b1;
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            stall_mem = 1'b1;
            bubble_wb = 1'b1;
            // Ack beats the timeout when both land on the same cycle.
            if (dmem_ack) begin
               w_done      = 1'b1;
               w_state_nxt = RESP;
            end else if (r_cnt == LP_CNT_LAST) begin
               w_tmo       = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            read_data_mem = w_rdata_ext;
            w_state_nxt   = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (reset) begin
         stall_mem        = 1'b0;
         bubble_wb        = 1'b0;
         read_data_mem    = 32'd0;
         misaligned_fault = 1'b0;
      end
   end

   assign timeout_fault = r_timeout;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_rdata_q  <= 32'd0;
         r_timeout  <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= 32'd0;
         dmem_wdata <= 32'd0;
         dmem_be    <= 4'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_timeout <= w_tmo;
         r_cnt     <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
         if (w_issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_mem;
            dmem_addr  <= {alu_result_mem[31:2], 2'b00};
            dmem_wdata <= w_wdata_rep;
            dmem_be    <= w_be;
         end
         if (w_done || w_tmo) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_be    <= 4'd0;
            r_rdata_q  <= (w_done && !dmem_we) ? dmem_rdata : 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl with a short timeout; expected
// load results are queued at issue and compared when the RESP cycle appears.
module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read_mem, mem_write_mem;
   logic [31:0] alu_result_mem, write_data_mem;
   logic [2:0]  funct3_mem;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        stall_mem, bubble_wb;
   logic [31:0] read_data_mem;
   logic        misaligned_fault, timeout_fault;

   int n_chk  = 0;
   int n_pass = 0;

   logic [32:0] sb_q[$];
   logic        prev_stall = 1'b0;

   typedef struct {
      logic [2:0]  f3;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rdata;
      int          ack_at;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic [31:0] e_rd;
      logic        e_tmo;
   } vec_t;

   vec_t vecs[12];

   always #5 clk = ~clk;

   dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .mem_read_mem     (mem_read_mem),
      .mem_write_mem    (mem_write_mem),
      .alu_result_mem   (alu_result_mem),
      .write_data_mem   (write_data_mem),
      .funct3_mem       (funct3_mem),
      .dmem_req         (dmem_req),
      .dmem_we          (dmem_we),
      .dmem_addr        (dmem_addr),
      .dmem_wdata       (dmem_wdata),
      .dmem_be          (dmem_be),
      .dmem_ack         (dmem_ack),
      .dmem_rdata       (dmem_rdata),
      .stall_mem        (stall_mem),
      .bubble_wb        (bubble_wb),
      .read_data_mem    (read_data_mem),
      .misaligned_fault (misaligned_fault),
      .timeout_fault    (timeout_fault)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp)
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      else
         n_pass++;
   endtask

   // RESP is the first non-stalled cycle after a stalled one outside reset.
   always @(negedge clk) begin
      logic [32:0] e;
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && !stall_mem) begin
            if (sb_q.size() == 0) begin
               chk("sb_empty", 32'(sb_q.size()), 32'd1);
            end else begin
               e = sb_q.pop_front();
               chk("resp_rdata", read_data_mem, e[31:0]);
               chk("resp_tmo", {31'd0, timeout_fault}, {31'd0, e[32]});
               chk("resp_bubble", {31'd0, bubble_wb}, 32'd0);
            end
         end
         prev_stall = stall_mem;
      end
   end

   task automatic clear_inputs();
      mem_read_mem   = 1'b0;
      mem_write_mem  = 1'b0;
      alu_result_mem = 32'd0;
      write_data_mem = 32'd0;
      funct3_mem     = 3'd0;
   endtask

   task automatic do_access(input vec_t v);
      int   waits;
      int   exp_waits;
      logic got_resp;
      waits     = 0;
      got_resp  = 1'b0;
      exp_waits = (v.ack_at == 0) ? 4 : v.ack_at;
      @(posedge clk); #1;
      mem_read_mem   = v.rd;
      mem_write_mem  = v.wr;
      alu_result_mem = v.addr;
      write_data_mem = v.wd;
      funct3_mem     = v.f3;
      #1;
      chk("idle_stall", {31'd0, stall_mem}, 32'd1);
      chk("idle_bubble", {31'd0, bubble_wb}, 32'd1);
      chk("idle_mis", {31'd0, misaligned_fault}, 32'd0);
      sb_q.push_back({v.e_tmo, v.e_rd});
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         dmem_ack   = 1'b0;
         dmem_rdata = $urandom;
         #1;
         if (!stall_mem) begin
            got_resp = 1'b1;
            break;
         end
         waits++;
         chk("wait_req", {31'd0, dmem_req}, 32'd1);
         if (k == 1) begin
            chk("wait_addr", dmem_addr, {v.addr[31:2], 2'b00});
            chk("wait_be", {28'd0, dmem_be}, {28'd0, v.e_be});
            chk("wait_we", {31'd0, dmem_we}, {31'd0, v.wr});
            if (v.wr) chk("wait_wdata", dmem_wdata, v.e_wdata);
         end
         if (k == v.ack_at) begin
            dmem_ack   = 1'b1;
            dmem_rdata = v.rdata;
         end
      end
      chk("resp_seen", {31'd0, got_resp}, 32'd1);
      chk("wait_cycles", 32'(waits), 32'(exp_waits));
      chk("resp_req", {31'd0, dmem_req}, 32'd0);
   endtask

   task automatic do_bad(input logic [2:0] f3, input logic [31:0] addr, input logic wr);
      @(posedge clk); #1;
      mem_read_mem   = ~wr;
      mem_write_mem  = wr;
      alu_result_mem = addr;
      write_data_mem = 32'h1234_5678;
      funct3_mem     = f3;
      #1;
      chk("bad_mis", {31'd0, misaligned_fault}, 32'd1);
      chk("bad_stall", {31'd0, stall_mem}, 32'd0);
      chk("bad_rdata", read_data_mem, 32'd0);
      @(posedge clk); #1;
      clear_inputs();
      #1;
      chk("bad_req", {31'd0, dmem_req}, 32'd0);
      chk("bad_mis_end", {31'd0, misaligned_fault}, 32'd0);
   endtask

   task automatic do_reset_in_wait();
      @(posedge clk); #1;
      mem_read_mem   = 1'b1;
      alu_result_mem = 32'h0000_0800;
      funct3_mem     = 3'b010;
      @(posedge clk); #1;
      chk("rst_w1_req", {31'd0, dmem_req}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      clear_inputs();
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hFFFF_FFFF;
      #1;
      chk("rst_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_stall", {31'd0, stall_mem}, 32'd0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      #1;
      chk("late_ack_req", {31'd0, dmem_req}, 32'd0);
      chk("late_ack_stall", {31'd0, stall_mem}, 32'd0);
      chk("late_ack_rdata", read_data_mem, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{3'b010, 1'b1, 1'b0, 32'h0000_0100, 32'h0,          32'hDEAD_BEEF, 3, 4'b1111, 32'h0,          32'hDEAD_BEEF, 1'b0};
      vecs[1]  = '{3'b000, 1'b1, 1'b0, 32'h0000_0203, 32'h0,          32'h8012_3456, 2, 4'b1111, 32'h0,          32'hFFFF_FF80, 1'b0};
      vecs[2]  = '{3'b100, 1'b1, 1'b0, 32'h0000_0203, 32'h0,          32'h8012_3456, 2, 4'b1111, 32'h0,          32'h0000_0080, 1'b0};
      vecs[3]  = '{3'b001, 1'b0, 1'b1, 32'h0000_0302, 32'h0000_ABCD, 32'h5555_5555, 1, 4'b1100, 32'hABCD_ABCD, 32'h0,          1'b0};
      vecs[4]  = '{3'b010, 1'b1, 1'b0, 32'h0000_0400, 32'h0,          32'h1111_1111, 0, 4'b1111, 32'h0,          32'h0,          1'b1};
      vecs[5]  = '{3'b010, 1'b1, 1'b0, 32'h0000_0404, 32'h0,          32'h1234_5678, 4, 4'b1111, 32'h0,          32'h1234_5678, 1'b0};
      vecs[6]  = '{3'b001, 1'b1, 1'b0, 32'h0000_0502, 32'h0,          32'h8001_7FFF, 1, 4'b1111, 32'h0,          32'hFFFF_8001, 1'b0};
      vecs[7]  = '{3'b101, 1'b1, 1'b0, 32'h0000_0500, 32'h0,          32'h8001_F00F, 2, 4'b1111, 32'h0,          32'h0000_F00F, 1'b0};
      vecs[8]  = '{3'b000, 1'b0, 1'b1, 32'h0000_0601, 32'h1234_56A5, 32'h0,          1, 4'b0010, 32'hA5A5_A5A5, 32'h0,          1'b0};
      vecs[9]  = '{3'b010, 1'b0, 1'b1, 32'h0000_0604, 32'hCAFE_F00D, 32'h0,          3, 4'b1111, 32'hCAFE_F00D, 32'h0,          1'b0};
      vecs[10] = '{3'b000, 1'b1, 1'b0, 32'h0000_0700, 32'h0,          32'h0000_007F, 1, 4'b1111, 32'h0,          32'h0000_007F, 1'b0};
      vecs[11] = '{3'b000, 1'b1, 1'b1, 32'h0000_0703, 32'h0000_0077, 32'hFFFF_FFFF, 2, 4'b1000, 32'h7777_7777, 32'h0,          1'b0};

      dmem_ack   = 1'b0;
      dmem_rdata = 32'd0;
      reset      = 1'b1;
      mem_read_mem   = 1'b1;
      mem_write_mem  = 1'b0;
      alu_result_mem = 32'h0000_0101;
      write_data_mem = 32'd0;
      funct3_mem     = 3'b010;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req0", {31'd0, dmem_req}, 32'd0);
      chk("rst_be0", {28'd0, dmem_be}, 32'd0);
      chk("rst_stall0", {31'd0, stall_mem}, 32'd0);
      chk("rst_mis0", {31'd0, misaligned_fault}, 32'd0);
      chk("rst_tmo0", {31'd0, timeout_fault}, 32'd0);
      chk("rst_rdata0", read_data_mem, 32'd0);
      clear_inputs();
      reset = 1'b0;

      for (int i = 0; i < 6; i++) do_access(vecs[i]);
      do_bad(3'b010, 32'h0000_0101, 1'b0);
      do_bad(3'b001, 32'h0000_0301, 1'b0);
      do_bad(3'b010, 32'h0000_0102, 1'b1);
      do_bad(3'b011, 32'h0000_0100, 1'b0);
      for (int i = 6; i < 12; i++) do_access(vecs[i]);
      do_reset_in_wait();
      do_access(vecs[0]);
      @(posedge clk); #1;
      clear_inputs();
      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      chk("idle_req_end", {31'd0, dmem_req}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences MEM-stage loads/stores onto a variable-latency data memory over a req/ack handshake.
- Freezes IF..MEM and inserts a bubble into MEM/WB while an access is outstanding.
- Produces byte-lane-aligned, sign/zero-extended load data for MEM/WB read_data_mem.
- Flags misaligned/illegal-width accesses and memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: max WAIT cycles without dmem_ack before abort; range 1..255, counter 8 bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- mem_read_mem  in  1  MEM-stage instruction is a load
- mem_write_mem  in  1  MEM-stage instruction is a store
- alu_result_mem  in  32  byte address
- write_data_mem  in  32  store data (rs2)
- funct3_mem  in  3  access width/sign
- dmem_req  out  1  request valid, registered
- dmem_we  out  1  write strobe, registered
- dmem_addr  out  32  word address {addr[31:2],2'b00}, registered
- dmem_wdata  out  32  lane-replicated store data, registered
- dmem_be  out  4  byte enables, registered
- dmem_ack  in  1  one-cycle completion pulse
- dmem_rdata  in  32  read word, valid with dmem_ack
- stall_mem  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- bubble_wb  out  1  force MEM/WB reg_write_wb to 0 this edge
- read_data_mem  out  32  extended load data to MEM/WB
- misaligned_fault  out  1  one-cycle pulse, no access issued
- timeout_fault  out  1  one-cycle pulse

Behaviour:
- Clocking/reset: single clock clk; reset synchronous active-high. While reset is high, all outputs are 0, state = IDLE, counter = 0, rdata_q = 0.
- access = mem_read_mem | mem_write_mem. Both high: treated as a store.
- Legality:
  - funct3[1:0]==11 is illegal.
  - Halfword needs addr[0]==0; word needs addr[1:0]==00.
  - bad = access & (illegal | misaligned).
- IDLE:
  - access & !bad: register dmem_req=1, plus we/addr/wdata/be; go to WAIT. stall_mem=1 and bubble_wb=1 combinationally this cycle.
  - bad: misaligned_fault=1 combinationally, no request, no stall; read_data_mem=0; stay IDLE.
  - No access: stall_mem=0, bubble_wb=0, read_data_mem=0.
- WAIT:
  - stall_mem=1, bubble_wb=1.
  - dmem_req and all dmem_* stay stable until the cycle after ack or timeout.
  - Counter increments each WAIT cycle.
  - dmem_ack: capture dmem_rdata into rdata_q (loads only; stores capture 0), clear req, go to RESP.
  - Counter reaches TIMEOUT_CYCLES with no ack: clear req, rdata_q=0, timeout_fault=1 registered (visible in RESP), go to RESP.
  - Ack in the same cycle as the limit: ack wins, no fault.
- RESP:
  - stall_mem=0, bubble_wb=0; read_data_mem = extend(rdata_q).
  - Pipeline advances at the end of this cycle; next state IDLE, counter cleared. No new request is issued in RESP.
- dmem_ack outside WAIT is ignored.
- Reset in WAIT drops dmem_req at that edge. The memory must tolerate the abandoned request.
- Minimum access cost: IDLE(1) + WAIT(>=1) + RESP(1). Back-to-back accesses re-enter IDLE between them.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{wd[7:0]}}.
  - SH: be=0011<<addr[1:0], wdata={2{wd[15:0]}}.
  - SW: be=1111.
  - Loads: be=1111, we=0.
- Load extension (lane = addr[1:0]):
  - 000 LB: sign-extend byte.
  - 100 LBU: zero-extend byte.
  - 001 LH: sign-extend halfword from addr[1].
  - 101 LHU: zero-extend halfword from addr[1].
  - 010 LW: full word.
- funct3 and address are held stable by stall_mem during WAIT/RESP, so extension uses live inputs plus rdata_q.

Decomposition:
- Package riscv_mem_pkg holds:
  - state enum {IDLE, WAIT, RESP}, 2 bits.
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW.
  - TIMEOUT counter width constant.
- Sub-module lsu_align (combinational) owns legality check, byte enables, wdata replication and load extension. The FSM, counter and registers stay in dmem_access_ctrl.

Test Plan:
- LW addr 0x100, ack after 3 WAIT cycles with rdata 0xDEADBEEF -> dmem_addr=0x100, be=1111; stall_mem high 4 cycles; RESP read_data_mem=0xDEADBEEF, stall low.
- LB addr 0x203, rdata 0x80123456 -> be=1111; read_data_mem=0xFFFFFF80. LBU same -> 0x00000080.
- SH addr 0x302, wd=0x0000ABCD, ack after 1 cycle -> we=1, be=1100, wdata=0xABCDABCD, dmem_addr=0x300; read_data_mem=0.
- LW addr 0x101 -> misaligned_fault pulse, dmem_req never rises, stall_mem=0.
- TIMEOUT_CYCLES=4, no ack -> req drops after 4 WAIT cycles; timeout_fault=1 in RESP; read_data_mem=0. Repeat with ack on the 4th cycle -> no fault.
- Reset asserted in the 2nd WAIT cycle -> next cycle dmem_req=0, stall_mem=0, state IDLE. A late ack is then ignored.
